// File: rtl/design_sel_pkg.sv
// Shared definitions for the design-select controller.
//   sel_state_e : controller FSM states
//   NUM_DESIGNS : highest valid design number (1..NUM_DESIGNS)
//   SEL_W       : width of a design select value
//   map_sel     : clamps an out-of-range request to "none" (0)
//   is_bad_sel  : flags a request above NUM_DESIGNS
package design_sel_pkg;

    localparam int NUM_DESIGNS = 12;
    localparam int SEL_W       = 4;

    localparam logic [SEL_W-1:0] MAX_SEL = SEL_W'(NUM_DESIGNS);

    typedef enum logic [1:0] {
        ST_OFF    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HOLD   = 2'd2,
        ST_ACTIVE = 2'd3
    } sel_state_e;

    function automatic logic is_bad_sel(input logic [SEL_W-1:0] sel);
        return (sel > MAX_SEL);
    endfunction

    function automatic logic [SEL_W-1:0] map_sel(input logic [SEL_W-1:0] sel);
        return is_bad_sel(sel) ? '0 : sel;
    endfunction

endpackage

// File: rtl/sel_cycle_timer.sv
// Loadable down-counter that saturates at zero.
//   clk      : clock
//   rst      : synchronous active-high reset, clears the count
//   load_i   : load load_val_i this cycle (has priority over counting)
//   load_val_i : value to load
//   done_o   : count is zero
module sel_cycle_timer #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             done_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/design_select_ctrl.sv
// Sequences a switch of the downstream design mux: deselect and drain,
// hold the new design in reset, then release it.
//   clk, rst       : clock, synchronous active-high reset
//   cfg_valid/sel  : select request (0 = none, 1..12 = design)
//   cfg_ready      : request accepted when cfg_valid & cfg_ready
//   cfg_err        : one-cycle pulse after an out-of-range request
//   design_select  : select to the design mux
//   design_n_rst   : active-low reset to the design mux
//   active_sel     : running design, 0 when none or switching
//   busy           : switch sequence in progress
//
// state     | meaning
// ----------+----------------------------------------------------
// ST_OFF    | nothing selected, accepting requests
// ST_DRAIN  | all designs deselected for DRAIN_CYCLES
// ST_HOLD   | target selected but held in reset for RESET_CYCLES
// ST_ACTIVE | target running, accepting requests
module design_select_ctrl
    import design_sel_pkg::*;
#(
    parameter int DRAIN_CYCLES = 4,
    parameter int RESET_CYCLES = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    input  logic [SEL_W-1:0] cfg_sel,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic [SEL_W-1:0] design_select,
    output logic             design_n_rst,
    output logic [SEL_W-1:0] active_sel,
    output logic             busy
);

    localparam int DRAIN_EFF = (DRAIN_CYCLES < 1) ? 1 : DRAIN_CYCLES;
    localparam int RESET_EFF = (RESET_CYCLES < 1) ? 1 : RESET_CYCLES;
    localparam int CNT_MAX   = (DRAIN_EFF > RESET_EFF) ? DRAIN_EFF : RESET_EFF;
    localparam int CNT_W     = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);

    // Counter is loaded with N-1 so that done is seen on the Nth cycle.
    localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_EFF - 1);
    localparam logic [CNT_W-1:0] RESET_LOAD = CNT_W'(RESET_EFF - 1);

    sel_state_e       state_q, state_d;
    logic [SEL_W-1:0] target_q, target_d;
    logic             ready_q, ready_d;
    logic             err_q, err_d;
    logic [SEL_W-1:0] dsel_q, dsel_d;
    logic             nrst_q, nrst_d;
    logic [SEL_W-1:0] act_q, act_d;
    logic             busy_q, busy_d;

    logic             accept;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic             tmr_done;

    sel_cycle_timer #(.CNT_W(CNT_W)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .done_o     (tmr_done)
    );

    assign accept = cfg_valid && ready_q;

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        err_d    = 1'b0;
        tmr_load = 1'b0;
        tmr_val  = '0;
        case (state_q)
            ST_OFF, ST_ACTIVE: begin
                // A request equal to the running design still goes through
                // the full sequence: it is the soft-reset path.
                if (accept) begin
                    state_d  = ST_DRAIN;
                    target_d = map_sel(cfg_sel);
                    err_d    = is_bad_sel(cfg_sel);
                    tmr_load = 1'b1;
                    tmr_val  = DRAIN_LOAD;
                end
            end
            ST_DRAIN: begin
                if (tmr_done) begin
                    tmr_load = 1'b1;
                    if (target_q != '0) begin
                        state_d = ST_HOLD;
                        tmr_val = RESET_LOAD;
                    end else begin
                        state_d = ST_OFF;
                    end
                end
            end
            ST_HOLD: begin
                if (tmr_done) begin
                    state_d  = ST_ACTIVE;
                    tmr_load = 1'b1;
                end
            end
            default: state_d = ST_OFF;
        endcase
    end

    // Outputs are decoded from the next state and registered, so every
    // output is a flop and the mux select/reset never glitch.
    always_comb begin
        ready_d = (state_d == ST_OFF) || (state_d == ST_ACTIVE);
        dsel_d  = ((state_d == ST_HOLD) || (state_d == ST_ACTIVE)) ? target_d : '0;
        nrst_d  = (state_d == ST_ACTIVE);
        act_d   = (state_d == ST_ACTIVE) ? target_d : '0;
        busy_d  = (state_d == ST_DRAIN) || (state_d == ST_HOLD);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_OFF;
            target_q <= '0;
            ready_q  <= 1'b0;
            err_q    <= 1'b0;
            dsel_q   <= '0;
            nrst_q   <= 1'b0;
            act_q    <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            ready_q  <= ready_d;
            err_q    <= err_d;
            dsel_q   <= dsel_d;
            nrst_q   <= nrst_d;
            act_q    <= act_d;
            busy_q   <= busy_d;
        end
    end

    assign cfg_ready     = ready_q;
    assign cfg_err       = err_q;
    assign design_select = dsel_q;
    assign design_n_rst  = nrst_q;
    assign active_sel    = act_q;
    assign busy          = busy_q;

endmodule

// File: doc/design_select_ctrl.md
DESIGN_SELECT_CTRL -- requirements
Module: design_select_ctrl

Interface
REQ-001 SHALL have parameter DRAIN_CYCLES, default 4: cycles all designs are deselected before a switch.
REQ-002 SHALL have parameter RESET_CYCLES, default 8: cycles the newly selected design is held in reset.
REQ-003 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port cfg_valid, input, 1: a select request is present.
REQ-006 SHALL have port cfg_sel, input, 4: requested design number (0 = none, 1-12 = design).
REQ-007 SHALL have port cfg_ready, output, 1: the block accepts a request this cycle.
REQ-008 SHALL have port cfg_err, output, 1: one-cycle pulse when an out-of-range request is accepted.
REQ-009 SHALL have port design_select, output, 4: drives the select input of the downstream design mux.
REQ-010 SHALL have port design_n_rst, output, 1: active-low reset to the downstream design mux.
REQ-011 SHALL have port active_sel, output, 4: design currently running; 0 when none or switching.
REQ-012 SHALL have port busy, output, 1: a switch sequence is in progress.

Function
REQ-013 SHALL implement states OFF, DRAIN, HOLD and ACTIVE.
REQ-014 SHALL accept a request only on a cycle with cfg_valid and cfg_ready both high.
REQ-015 SHALL drive cfg_ready high in OFF and ACTIVE, and low in DRAIN and HOLD.
REQ-016 SHALL latch the accepted cfg_sel into a target register, mapping values 13-15 to 0 and pulsing cfg_err high on the cycle after acceptance.
REQ-017 SHALL move from OFF or ACTIVE to DRAIN on acceptance, including a request equal to the current selection, which acts as a soft reset of that design.
REQ-018 SHALL drive, in DRAIN: design_select = 0, design_n_rst = 0, busy = 1, active_sel = 0.
REQ-019 SHALL remain in DRAIN for exactly DRAIN_CYCLES cycles, then go to HOLD if target is nonzero, else to OFF.
REQ-020 SHALL drive, in HOLD: design_select = target, design_n_rst = 0, busy = 1, active_sel = 0.
REQ-021 SHALL remain in HOLD for exactly RESET_CYCLES cycles, then go to ACTIVE.
REQ-022 SHALL drive, in ACTIVE: design_select = target, design_n_rst = 1, busy = 0, active_sel = target.
REQ-023 SHALL drive, in OFF: design_select = 0, design_n_rst = 0, busy = 0, active_sel = 0.
REQ-024 SHALL register all outputs, so they change only on a clock edge, and SHALL drive design_select and design_n_rst glitch-free.
REQ-025 SHALL ignore cfg_valid while cfg_ready is low; requests are neither queued nor merged.
REQ-026 SHALL size the cycle counter to hold max(DRAIN_CYCLES, RESET_CYCLES), reload it on every state entry, and never wrap.
REQ-027 SHALL treat DRAIN_CYCLES or RESET_CYCLES = 0 as 1.

Reset
REQ-028 SHALL, on any clock edge with rst high, enter OFF from any state, including mid-DRAIN or mid-HOLD.
REQ-029 SHALL, on that edge, clear the target register and counter to 0.
REQ-030 SHALL, on that edge, drive cfg_ready = 0, cfg_err = 0, design_select = 0, design_n_rst = 0, active_sel = 0 and busy = 0.
REQ-031 SHALL raise cfg_ready in the first cycle after rst deasserts.

Structure
REQ-032 SHALL take the state enum, NUM_DESIGNS = 12 and the 4-bit select width from shared package design_sel_pkg.
REQ-033 SHALL place the loadable down-counter, with its done flag, in sub-module sel_cycle_timer.

Verification
REQ-034 SHALL cover a cold select: reset, then cfg_sel = 5 with valid -> 4 cycles of select 0, then 8 cycles of select 5 with design_n_rst = 0, then ACTIVE with design_n_rst = 1, active_sel = 5 and cfg_ready = 1.
REQ-035 SHALL cover a switch: ACTIVE on design 5, request 9 -> 4 cycles of select 0, 8 of select 9 in reset, then active_sel = 9; a request of 2 pulsed mid-HOLD is ignored.
REQ-036 SHALL cover a deselect: ACTIVE on design 3, request 0 -> 4 cycles of DRAIN, then OFF with design_select = 0 and busy = 0.
REQ-037 SHALL cover an invalid request: request 14 -> cfg_err high for exactly 1 cycle, DRAIN, then OFF; design_select never equals 14.
REQ-038 SHALL cover reset mid-HOLD: rst high on the 3rd HOLD cycle of a switch to 7 -> next edge gives design_select = 0, design_n_rst = 0, then cfg_ready = 1 after release.
REQ-039 SHALL cover a soft reset: ACTIVE on design 12, request 12 -> full DRAIN (4) and HOLD (8) sequence, then active_sel = 12.
